adc1sndr: RTL and testbench

- Fabric-side transmitter for one ADC-style serial data line.
- Each WIDTH-bit word is serialized MSB-first as bit pairs, one pair per CLK cycle, for an external ODDR2 and LVDS output buffer. A matching frame-clock pair stream is produced alongside.
- Used as an ADC emulator and link-training source for the per-line deserializer. Supports user data, fixed pattern, ramp and PRBS7 sources.
- Supports programmable 1-bit stream slips, so receiver bitslip alignment and delay calibration can be exercised in loopback.

---
 rtl/adc1sndr_if.sv | 26 ++
 rtl/adc1sndr.sv | 158 +++++++++++++++
 tb/tb_adc1sndr.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/adc1sndr_if.sv
// Word-side and line-side signals of the single-line ADC transmitter.
// The source (bench or fabric) uses the master view; adc1sndr uses the slave view.
interface adc1sndr_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] DIN;
    logic             DVALID;
    logic             DREADY;
    logic [1:0]       MODE;
    logic [WIDTH-1:0] PAT;
    logic             SLIP;
    logic [1:0]       DOUT;
    logic [1:0]       FOUT;
    logic             WSTRB;
    logic             UNDERRUN;

    modport master (
        output DIN, DVALID, MODE, PAT, SLIP,
        input  DREADY, DOUT, FOUT, WSTRB, UNDERRUN
    );

    modport slave (
        input  DIN, DVALID, MODE, PAT, SLIP,
        output DREADY, DOUT, FOUT, WSTRB, UNDERRUN
    );
endinterface

// File: rtl/adc1sndr.sv
// Serializes WIDTH-bit words MSB-first as bit pairs (one pair per CLK) for an ODDR2,
// with a matching frame-clock pair stream, test-pattern sources and 1-bit stream slips.
module adc1sndr #(
    parameter int WIDTH = 6
) (
    input  logic       CLK,
    input  logic       RST,
    adc1sndr_if.slave  bus
);
    localparam int P  = WIDTH / 2;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int OW = $clog2(WIDTH);
    localparam logic [PW-1:0]    PH_LAST   = PW'(P - 1);
    localparam logic [OW-1:0]    OFF_LAST  = OW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] FCLK      = {{(WIDTH / 2){1'b1}}, {(WIDTH - WIDTH / 2){1'b0}}};
    localparam logic [6:0]       PRBS_SEED = 7'h7F;

    // Pair sent during phase ph: frame bits 2*ph (first) and 2*ph+1.
    function automatic logic [1:0] pair_of(input logic [WIDTH-1:0] frame, input logic [PW-1:0] ph);
        logic [WIDTH-1:0] sh;
        sh = frame << {ph, 1'b0};
        return 2'(sh >> (WIDTH - 2));
    endfunction

    function automatic logic [WIDTH-1:0] frame_of(input logic [2*WIDTH-1:0] hist, input logic [OW-1:0] off);
        return WIDTH'(hist >> off);
    endfunction

    // Advances PRBS7 by WIDTH bits; returns {new state, word}, oldest state bit in s[6].
    function automatic logic [6+WIDTH:0] prbs_next(input logic [6:0] s_in);
        logic [6:0]       s;
        logic [WIDTH-1:0] w;
        logic             nb;
        s = s_in;
        w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            nb = s[6] ^ s[5];
            s  = {s[5:0], nb};
            w  = {w[WIDTH-2:0], nb};
        end
        return {s, w};
    endfunction

    logic [PW-1:0]      r_ph;
    logic [OW-1:0]      r_off;
    logic [2*WIDTH-1:0] r_hist;
    logic [WIDTH-1:0]   r_ramp;
    logic [6:0]         r_prbs;
    logic [1:0]         r_last_mode;
    logic               r_slip_req;
    logic [1:0]         r_dout;
    logic [1:0]         r_fout;
    logic               r_wstrb;
    logic               r_underrun;

    logic               w_load;
    logic               w_slip_any;
    logic [6+WIDTH:0]   w_prbs_res;
    logic [WIDTH-1:0]   w_new;
    logic [PW-1:0]      w_ph_next;
    logic [OW-1:0]      w_off_next;
    logic [2*WIDTH-1:0] w_hist_next;
    logic [WIDTH-1:0]   w_ramp_next;
    logic [6:0]         w_prbs_next;
    logic [1:0]         w_mode_next;
    logic               w_slip_next;
    logic               w_under_next;

    // Next-state logic: phase advance, source word selection and slip at the load edge.
    always_comb begin
        w_load       = (r_ph == PH_LAST);
        w_slip_any   = r_slip_req | bus.SLIP;
        w_prbs_res   = prbs_next((r_last_mode == 2'd3) ? r_prbs : PRBS_SEED);
        w_new        = '0;
        w_ph_next    = r_ph + PW'(1);
        w_off_next   = r_off;
        w_hist_next  = r_hist;
        w_ramp_next  = r_ramp;
        w_prbs_next  = r_prbs;
        w_mode_next  = r_last_mode;
        w_slip_next  = w_slip_any;
        w_under_next = r_underrun;
        if (w_load) begin
            w_ph_next   = '0;
            w_mode_next = bus.MODE;
            case (bus.MODE)
                2'd0: begin
                    if (bus.DVALID) begin
                        w_new = bus.DIN;
                    end else begin
                        w_new        = '0;
                        w_under_next = 1'b1;
                    end
                end
                2'd1: w_new = bus.PAT;
                2'd2: begin
                    // Entering ramp mode restarts the count so the first frame is zero.
                    if (r_last_mode == 2'd2) begin
                        w_new       = r_ramp;
                        w_ramp_next = r_ramp + WIDTH'(1);
                    end else begin
                        w_new       = '0;
                        w_ramp_next = WIDTH'(1);
                    end
                end
                2'd3: begin
                    w_new       = w_prbs_res[WIDTH-1:0];
                    w_prbs_next = w_prbs_res[6+WIDTH:WIDTH];
                end
                default: w_new = '0;
            endcase
            w_hist_next = {r_hist[WIDTH-1:0], w_new};
            if (w_slip_any) begin
                w_off_next = (r_off == OFF_LAST) ? '0 : r_off + OW'(1);
            end else begin
                w_off_next = r_off;
            end
            w_slip_next = 1'b0;
        end else begin
            w_new = '0;
        end
    end

    // State and registered line outputs; outputs show the pair for the upcoming phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ph        <= PH_LAST;
            r_off       <= '0;
            r_hist      <= '0;
            r_ramp      <= '0;
            r_prbs      <= PRBS_SEED;
            r_last_mode <= 2'd0;
            r_slip_req  <= 1'b0;
            r_dout      <= 2'b00;
            r_fout      <= 2'b00;
            r_wstrb     <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_ph        <= w_ph_next;
            r_off       <= w_off_next;
            r_hist      <= w_hist_next;
            r_ramp      <= w_ramp_next;
            r_prbs      <= w_prbs_next;
            r_last_mode <= w_mode_next;
            r_slip_req  <= w_slip_next;
            r_dout      <= pair_of(frame_of(w_hist_next, w_off_next), w_ph_next);
            r_fout      <= pair_of(FCLK, w_ph_next);
            r_wstrb     <= (w_ph_next == '0);
            r_underrun  <= w_under_next;
        end
    end

    assign bus.DREADY   = w_load && (bus.MODE == 2'd0) && !RST;
    assign bus.DOUT     = r_dout;
    assign bus.FOUT     = r_fout;
    assign bus.WSTRB    = r_wstrb;
    assign bus.UNDERRUN = r_underrun;
endmodule

// File: tb/tb_adc1sndr.sv
// Bench for adc1sndr: directed scenarios plus randomized traffic, every cycle compared
// against a frame-level reference model of the serial stream.
module tb_adc1sndr;
    localparam int W = 6;
    localparam int P = W / 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    adc1sndr_if #(.WIDTH(W)) bus ();

    adc1sndr #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (frame level)
    bit prbs_b[127];
    int m_ph, m_off, m_prev, m_cur, m_ramp, m_pos, m_last_mode, m_frame;
    bit m_slip, m_under, m_known;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model of what happens at the coming rising edge.
    task automatic model_edge();
        int w;
        if (RST) begin
            m_ph = P - 1; m_off = 0; m_prev = 0; m_cur = 0; m_ramp = 0; m_pos = 7;
            m_last_mode = 0; m_slip = 0; m_under = 0; m_frame = 0; m_known = 1;
        end else if (m_known) begin
            if (m_ph == P - 1) begin
                w = 0;
                case (int'(bus.MODE))
                    0: if (bus.DVALID) w = int'(bus.DIN); else m_under = 1;
                    1: w = int'(bus.PAT);
                    2: begin
                        if (m_last_mode != 2) m_ramp = 0;
                        w = m_ramp;
                        m_ramp = (m_ramp + 1) % (1 << W);
                    end
                    default: begin
                        if (m_last_mode != 3) m_pos = 7;
                        for (int i = 0; i < W; i++) begin
                            w = w * 2 + int'(prbs_b[m_pos % 127]);
                            m_pos++;
                        end
                    end
                endcase
                m_last_mode = int'(bus.MODE);
                m_prev = m_cur;
                m_cur  = w;
                if (m_slip || bus.SLIP) m_off = (m_off + 1) % W;
                m_slip  = 0;
                m_frame = ((m_prev * (1 << W) + m_cur) >> m_off) % (1 << W);
                m_ph = 0;
            end else begin
                m_slip = m_slip || bus.SLIP;
                m_ph++;
            end
        end
    endtask

    // One clock cycle: compare current outputs with the model, then advance both.
    task automatic cyc();
        int exp_dout, exp_fout;
        #1;
        if (m_known) begin
            exp_dout = ((m_frame >> (W - 1 - 2 * m_ph)) % 2) * 2 + ((m_frame >> (W - 2 - 2 * m_ph)) % 2);
            exp_fout = ((2 * m_ph < W / 2) ? 2 : 0) + ((2 * m_ph + 1 < W / 2) ? 1 : 0);
            check_eq("dready", bus.DREADY, (m_ph == P - 1) && (bus.MODE == 2'd0) && !RST);
            check_eq("dout", bus.DOUT, exp_dout);
            check_eq("fout", bus.FOUT, exp_fout);
            check_eq("wstrb", bus.WSTRB, m_ph == 0);
            check_eq("underrun", bus.UNDERRUN, m_under);
        end
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Runs one frame starting in the load cycle; slips[2] is the load cycle's SLIP.
    task automatic run_frame(input logic [2:0] slips, output logic [5:0] pairs);
        logic [2:0] sl;
        sl = slips;
        pairs = '0;
        for (int c = 0; c < P; c++) begin
            bus.SLIP = sl[P - 1 - c];
            cyc();
            pairs = {pairs[3:0], bus.DOUT};
        end
        bus.SLIP = 1'b0;
    endtask

    logic [5:0] pr;

    initial begin
        for (int n = 0; n < 127; n++) begin
            if (n < 7) prbs_b[n] = 1'b1;
            else       prbs_b[n] = prbs_b[n - 7] ^ prbs_b[n - 6];
        end
        m_known = 0;
        bus.DIN = 6'b101100; bus.DVALID = 1'b1; bus.MODE = 2'd0; bus.PAT = 6'h00; bus.SLIP = 1'b0;
        @(negedge CLK);
        RST = 1'b1; cyc(); cyc();
        RST = 1'b0;
        check_eq("rst_dout", bus.DOUT, 2'b00);
        check_eq("rst_under", bus.UNDERRUN, 1'b0);

        // Basic user word
        run_frame(3'b000, pr); check_eq("basic_frame", pr, 6'b101100);
        run_frame(3'b000, pr);

        // Underrun and stickiness
        bus.DVALID = 1'b0;
        run_frame(3'b000, pr); check_eq("underrun_frame", pr, 6'b000000);
        check_eq("underrun_set", bus.UNDERRUN, 1'b1);
        bus.DVALID = 1'b1; bus.DIN = 6'h3F;
        run_frame(3'b000, pr); check_eq("underrun_sticky", bus.UNDERRUN, 1'b1);

        // Slip alignment
        bus.DIN = 6'h00; run_frame(3'b100, pr); check_eq("slip1_zero", pr, 6'b100000);
        bus.DIN = 6'h3F; run_frame(3'b000, pr); check_eq("slip1_ones", pr, 6'b011111);
        bus.DIN = 6'h00; run_frame(3'b010, pr);
        bus.DIN = 6'h3F; run_frame(3'b100, pr); check_eq("slip_double", pr, 6'b001111);
        for (int k = 0; k < 4; k++) begin
            bus.DIN = 6'h00; run_frame(3'b100, pr);
            bus.DIN = 6'h3F; run_frame(3'b000, pr);
        end
        check_eq("slip_restored", pr, 6'b111111);
        for (int k = 0; k < 3; k++) begin
            bus.DIN = (k % 2 == 0) ? 6'h00 : 6'h3F; run_frame(3'b100, pr);
        end

        // Reset in mid-frame with a non-zero offset
        bus.DIN = 6'h15;
        cyc(); cyc();
        RST = 1'b1; cyc(); RST = 1'b0;
        check_eq("mid_rst_dout", bus.DOUT, 2'b00);
        check_eq("mid_rst_fout", bus.FOUT, 2'b00);
        check_eq("mid_rst_wstrb", bus.WSTRB, 1'b0);
        check_eq("mid_rst_under", bus.UNDERRUN, 1'b0);
        bus.DIN = 6'b110101;
        run_frame(3'b000, pr); check_eq("post_rst_frame", pr, 6'b110101);

        // Ramp with wrap, mid-frame mode switch, ramp restart
        bus.MODE = 2'd2;
        for (int f = 0; f < 66; f++) begin
            run_frame(3'b000, pr); check_eq("ramp", pr, f % 64);
        end
        cyc();
        bus.MODE = 2'd1; bus.PAT = 6'h2A;
        cyc(); cyc();
        run_frame(3'b000, pr); check_eq("pat_frame", pr, 6'h2A);
        bus.MODE = 2'd2;
        run_frame(3'b000, pr); check_eq("ramp_restart0", pr, 6'd0);
        run_frame(3'b000, pr); check_eq("ramp_restart1", pr, 6'd1);

        // PRBS7 from reset
        bus.MODE = 2'd3;
        RST = 1'b1; cyc(); RST = 1'b0;
        run_frame(3'b000, pr); check_eq("prbs_f0", pr, 6'b000000);
        run_frame(3'b000, pr); check_eq("prbs_f1", pr, 6'b100000);
        for (int f = 0; f < 260; f++) run_frame(3'b000, pr);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) bus.MODE = 2'($urandom_range(3));
            bus.DIN    = 6'($urandom);
            bus.DVALID = ($urandom_range(9) != 0);
            bus.SLIP   = ($urandom_range(7) == 0);
            if ($urandom_range(31) == 0) bus.PAT = 6'($urandom);
            RST = ($urandom_range(199) == 0);
            cyc();
        end
        RST = 1'b0; bus.SLIP = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
